// File: rtl/maquina_vendas_param.sv
// maquina_vendas_param: parametrised vending controller core.
// Holds a writable price table, a saturating credit accumulator and an
// inactivity timer driven by a 1 Hz enable. Change is handed out one unit
// at a time over a ready/valid stream.
module maquina_vendas_param #(
    parameter int SEL_W         = 4,
    parameter int CRED_W        = 8,
    parameter int TIMEOUT_TICKS = 15,
    parameter int DEFAULT_PRICE = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              tick,
    input  logic              key_valid,
    input  logic [SEL_W-1:0]  key_code,
    input  logic              coin_valid,
    input  logic [CRED_W-1:0] coin_value,
    input  logic              cancel,
    input  logic              price_we,
    input  logic [SEL_W-1:0]  price_addr,
    input  logic [CRED_W-1:0] price_data,
    input  logic              change_ready,
    output logic              change_valid,
    output logic              dispense,
    output logic [SEL_W-1:0]  disp_prod,
    output logic              invalid_sel,
    output logic              coin_reject,
    output logic [CRED_W-1:0] credit,
    output logic [1:0]        estado
);

    localparam int DEPTH = 2 ** SEL_W;
    localparam int TIM_W = (TIMEOUT_TICKS < 1) ? 1 : $clog2(TIMEOUT_TICKS + 1);
    localparam logic [TIM_W-1:0]  TIMEOUT_VAL = TIM_W'(TIMEOUT_TICKS);
    localparam logic [CRED_W-1:0] RESET_PRICE = CRED_W'(DEFAULT_PRICE);
    localparam logic [CRED_W-1:0] CREDIT_MAX  = {CRED_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        PAY      = 2'b01,
        DISPENSE = 2'b10,
        REFUND   = 2'b11
    } state_t;

    state_t            state, state_nxt;
    logic [CRED_W-1:0] credit_r, credit_nxt;
    logic [SEL_W-1:0]  sel_r, sel_nxt;
    logic [CRED_W-1:0] price_lat, price_lat_nxt;
    logic [TIM_W-1:0]  timer, timer_nxt;
    logic              invalid_r, invalid_nxt;
    logic              reject_r, reject_nxt;

    logic [CRED_W-1:0] price_table [DEPTH];
    logic [CRED_W-1:0] key_price;
    logic [CRED_W:0]   credit_sum;
    logic [CRED_W-1:0] credit_sat;

    // A price of zero marks the product as absent.
    assign key_price = price_table[key_code];

    // Coins add into credit; anything above the maximum is silently dropped.
    assign credit_sum = {1'b0, credit_r} + {1'b0, coin_value};
    assign credit_sat = credit_sum[CRED_W] ? CREDIT_MAX : credit_sum[CRED_W-1:0];

    // Price table: all entries return to the default price on reset, and
    // writes are accepted in every state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                price_table[i] <= RESET_PRICE;
            end
        end else if (price_we) begin
            price_table[price_addr] <= price_data;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and datapath decisions; PAY judges the registered credit,
    // so a coin accepted this cycle is weighed against the price next cycle.
    always_comb begin
        state_nxt     = state;
        credit_nxt    = credit_r;
        sel_nxt       = sel_r;
        price_lat_nxt = price_lat;
        timer_nxt     = '0;
        invalid_nxt   = 1'b0;
        reject_nxt    = 1'b0;

        case (state)
            IDLE: begin
                if (coin_valid) begin
                    credit_nxt = credit_sat;
                end
                if (key_valid) begin
                    if (key_price == '0) begin
                        invalid_nxt = 1'b1;
                    end else begin
                        sel_nxt       = key_code;
                        price_lat_nxt = key_price;
                        state_nxt     = PAY;
                    end
                end
                if (state_nxt == IDLE && cancel && credit_r != '0) begin
                    state_nxt = REFUND;
                end
            end

            PAY: begin
                if (coin_valid) begin
                    credit_nxt = credit_sat;
                end
                if (credit_r >= price_lat) begin
                    state_nxt = DISPENSE;
                end else if (cancel) begin
                    state_nxt = REFUND;
                end else if (timer >= TIMEOUT_VAL) begin
                    state_nxt = REFUND;
                end else begin
                    // Still waiting: a new key reselects, activity restarts
                    // the inactivity count, otherwise ticks advance it.
                    timer_nxt = timer;
                    if (key_valid) begin
                        timer_nxt = '0;
                        if (key_price == '0) begin
                            invalid_nxt = 1'b1;
                        end else begin
                            sel_nxt       = key_code;
                            price_lat_nxt = key_price;
                        end
                    end else if (coin_valid) begin
                        timer_nxt = '0;
                    end else if (tick) begin
                        timer_nxt = timer + 1'b1;
                    end
                end
            end

            DISPENSE: begin
                reject_nxt = coin_valid;
                credit_nxt = credit_r - price_lat;
                state_nxt  = (credit_r != price_lat) ? REFUND : IDLE;
            end

            REFUND: begin
                reject_nxt = coin_valid;
                if (credit_r == '0) begin
                    state_nxt = IDLE;
                end else if (change_ready) begin
                    credit_nxt = credit_r - 1'b1;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Datapath registers; reset throws away any credit held.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            credit_r  <= '0;
            sel_r     <= '0;
            price_lat <= '0;
            timer     <= '0;
            invalid_r <= 1'b0;
            reject_r  <= 1'b0;
        end else begin
            credit_r  <= credit_nxt;
            sel_r     <= sel_nxt;
            price_lat <= price_lat_nxt;
            timer     <= timer_nxt;
            invalid_r <= invalid_nxt;
            reject_r  <= reject_nxt;
        end
    end

    // Output decode: dispense lasts exactly the one DISPENSE cycle.
    always_comb begin
        dispense     = (state == DISPENSE);
        disp_prod    = (state == DISPENSE) ? sel_r : '0;
        change_valid = (state == REFUND) && (credit_r != '0);
        invalid_sel  = invalid_r;
        coin_reject  = reject_r;
        credit       = credit_r;
        estado       = state;
    end

endmodule

// File: tb/tb_maquina_vendas_param.sv
// Self-checking bench for maquina_vendas_param with a scoreboard of
// expected dispense, change, invalid-select and coin-reject events.
module tb_maquina_vendas_param;

    localparam int SEL_W  = 4;
    localparam int CRED_W = 8;

    localparam logic [1:0] S_IDLE     = 2'b00;
    localparam logic [1:0] S_PAY      = 2'b01;
    localparam logic [1:0] S_DISPENSE = 2'b10;
    localparam logic [1:0] S_REFUND   = 2'b11;

    logic              clk;
    logic              reset_n;
    logic              tick;
    logic              key_valid;
    logic [SEL_W-1:0]  key_code;
    logic              coin_valid;
    logic [CRED_W-1:0] coin_value;
    logic              cancel;
    logic              price_we;
    logic [SEL_W-1:0]  price_addr;
    logic [CRED_W-1:0] price_data;
    logic              change_ready;
    logic              change_valid;
    logic              dispense;
    logic [SEL_W-1:0]  disp_prod;
    logic              invalid_sel;
    logic              coin_reject;
    logic [CRED_W-1:0] credit;
    logic [1:0]        estado;

    int compared   = 0;
    int mismatched = 0;

    int disp_q[$];
    int chg_q[$];
    int inv_q[$];
    int rej_q[$];

    int         units       = 0;
    logic [1:0] prev_estado = 2'b00;

    maquina_vendas_param #(
        .SEL_W(SEL_W),
        .CRED_W(CRED_W),
        .TIMEOUT_TICKS(15),
        .DEFAULT_PRICE(3)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .tick(tick),
        .key_valid(key_valid),
        .key_code(key_code),
        .coin_valid(coin_valid),
        .coin_value(coin_value),
        .cancel(cancel),
        .price_we(price_we),
        .price_addr(price_addr),
        .price_data(price_data),
        .change_ready(change_ready),
        .change_valid(change_valid),
        .dispense(dispense),
        .disp_prod(disp_prod),
        .invalid_sel(invalid_sel),
        .coin_reject(coin_reject),
        .credit(credit),
        .estado(estado)
    );

    // Free-running system clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case the run wanders off.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Drives one cycle of inputs, then returns them to idle just after the edge.
    task automatic applyStimulus(input logic kv, input logic [SEL_W-1:0] kc,
                                 input logic cv, input logic [CRED_W-1:0] cval,
                                 input logic canc, input logic tk);
        key_valid  = kv;
        key_code   = kc;
        coin_valid = cv;
        coin_value = cval;
        cancel     = canc;
        tick       = tk;
        @(posedge clk);
        #1;
        key_valid  = 1'b0;
        coin_valid = 1'b0;
        cancel     = 1'b0;
        tick       = 1'b0;
    endtask

    task automatic press_key(input logic [SEL_W-1:0] code);
        applyStimulus(1'b1, code, 1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic insert_coin(input logic [CRED_W-1:0] value);
        applyStimulus(1'b0, '0, 1'b1, value, 1'b0, 1'b0);
    endtask

    task automatic do_cancel();
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
    endtask

    task automatic pulse_tick();
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic write_price(input logic [SEL_W-1:0] addr, input logic [CRED_W-1:0] data);
        price_we   = 1'b1;
        price_addr = addr;
        price_data = data;
        @(posedge clk);
        #1;
        price_we = 1'b0;
    endtask

    // Steps cycles until the target state appears or the budget runs out.
    task automatic wait_state(input string tag, input logic [1:0] target, input int budget);
        int n = 0;
        while (estado !== target && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput(tag, estado, target);
    endtask

    // Scoreboard monitor: pops an expectation whenever the DUT emits an event.
    always @(negedge clk) begin
        if (!reset_n) begin
            units       = 0;
            prev_estado = S_IDLE;
        end else begin
            if (dispense) begin
                if (disp_q.size() == 0) checkOutput("disp_extra", dispense, 0);
                else checkOutput("disp_prod", disp_prod, disp_q.pop_front());
            end
            if (invalid_sel) begin
                if (inv_q.size() == 0) checkOutput("inv_extra", invalid_sel, 0);
                else checkOutput("inv_state", estado, inv_q.pop_front());
            end
            if (coin_reject) begin
                if (rej_q.size() == 0) checkOutput("rej_extra", coin_reject, 0);
                else checkOutput("rej_credit", credit, rej_q.pop_front());
            end
            if (change_valid && change_ready) units++;
            if (prev_estado == S_REFUND && estado == S_IDLE) begin
                if (chg_q.size() == 0) checkOutput("chg_extra", prev_estado, S_IDLE);
                else checkOutput("chg_units", units, chg_q.pop_front());
                units = 0;
            end
            prev_estado = estado;
        end
    end

    // Main sequence of scenarios.
    initial begin
        reset_n      = 1'b0;
        tick         = 1'b0;
        key_valid    = 1'b0;
        key_code     = '0;
        coin_valid   = 1'b0;
        coin_value   = '0;
        cancel       = 1'b0;
        price_we     = 1'b0;
        price_addr   = '0;
        price_data   = '0;
        change_ready = 1'b0;

        #12;
        checkOutput("rst_estado", estado, S_IDLE);
        checkOutput("rst_credit", credit, 0);
        checkOutput("rst_change_valid", change_valid, 0);
        checkOutput("rst_dispense", dispense, 0);
        checkOutput("rst_disp_prod", disp_prod, 0);
        #5 reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Exact payment with three unit coins.
        disp_q.push_back(5);
        press_key(4'd5);
        checkOutput("t1_pay", estado, S_PAY);
        insert_coin(8'd1);
        insert_coin(8'd1);
        insert_coin(8'd1);
        checkOutput("t1_credit", credit, 3);
        wait_state("t1_dispense", S_DISPENSE, 4);
        wait_state("t1_idle", S_IDLE, 4);
        checkOutput("t1_credit_after", credit, 0);
        checkOutput("t1_no_change", change_valid, 0);

        // Overpayment returns one unit of change.
        write_price(4'd2, 8'd4);
        disp_q.push_back(2);
        chg_q.push_back(1);
        change_ready = 1'b1;
        press_key(4'd2);
        insert_coin(8'd5);
        wait_state("t2_dispense", S_DISPENSE, 4);
        wait_state("t2_refund", S_REFUND, 4);
        checkOutput("t2_credit", credit, 1);
        checkOutput("t2_change_valid", change_valid, 1);
        wait_state("t2_idle", S_IDLE, 6);
        checkOutput("t2_credit_after", credit, 0);
        change_ready = 1'b0;

        // Absent product raises invalid_sel and leaves the machine idle.
        write_price(4'd7, 8'd0);
        inv_q.push_back(S_IDLE);
        press_key(4'd7);
        checkOutput("t3_stay_idle", estado, S_IDLE);
        idle_cycles(1);
        press_key(4'd1);
        checkOutput("t3_pay", estado, S_PAY);
        chg_q.push_back(0);
        do_cancel();
        wait_state("t3_idle", S_IDLE, 4);

        // Inactivity timeout, then change handed out under backpressure.
        press_key(4'd0);
        insert_coin(8'd2);
        for (int i = 0; i < 14; i++) begin
            pulse_tick();
            idle_cycles(1);
        end
        checkOutput("t4_still_pay", estado, S_PAY);
        pulse_tick();
        wait_state("t4_refund", S_REFUND, 3);
        checkOutput("t4_credit_hold", credit, 2);
        chg_q.push_back(2);
        change_ready = 1'b1;
        idle_cycles(1);
        change_ready = 1'b0;
        checkOutput("t4_credit_1", credit, 1);
        idle_cycles(1);
        checkOutput("t4_credit_held", credit, 1);
        checkOutput("t4_valid_held", change_valid, 1);
        change_ready = 1'b1;
        idle_cycles(1);
        change_ready = 1'b0;
        checkOutput("t4_credit_0", credit, 0);
        idle_cycles(1);
        checkOutput("t4_idle", estado, S_IDLE);

        // Saturating credit and a full 255-unit refund.
        insert_coin(8'd200);
        insert_coin(8'd100);
        checkOutput("t5_saturate", credit, 255);
        insert_coin(8'd10);
        checkOutput("t5_saturate_again", credit, 255);
        chg_q.push_back(255);
        change_ready = 1'b1;
        do_cancel();
        checkOutput("t5_refund", estado, S_REFUND);
        wait_state("t5_idle", S_IDLE, 300);
        checkOutput("t5_credit_after", credit, 0);
        change_ready = 1'b0;

        // A coin during DISPENSE is rejected and not credited.
        disp_q.push_back(5);
        press_key(4'd5);
        insert_coin(8'd3);
        wait_state("t6_dispense", S_DISPENSE, 4);
        rej_q.push_back(0);
        insert_coin(8'd4);
        checkOutput("t6_idle", estado, S_IDLE);
        checkOutput("t6_credit", credit, 0);
        idle_cycles(2);

        // Reset in the middle of a refund drops everything at once.
        disp_q.push_back(2);
        press_key(4'd2);
        insert_coin(8'd9);
        wait_state("t7_refund", S_REFUND, 5);
        checkOutput("t7_credit", credit, 5);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("t7_rst_estado", estado, S_IDLE);
        checkOutput("t7_rst_credit", credit, 0);
        checkOutput("t7_rst_change_valid", change_valid, 0);
        #4 reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Reset restored the default price for the entry zeroed earlier.
        press_key(4'd7);
        checkOutput("t7_price_restored", estado, S_PAY);
        chg_q.push_back(0);
        do_cancel();
        wait_state("t7_idle", S_IDLE, 4);
        idle_cycles(2);

        checkOutput("pending_disp", disp_q.size(), 0);
        checkOutput("pending_chg", chg_q.size(), 0);
        checkOutput("pending_inv", inv_q.size(), 0);
        checkOutput("pending_rej", rej_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/maquina_vendas_param.md
Name: maquina_vendas_param

Overview:
- Parametrised next-generation vending controller core. Replaces the fixed 2x2 keypad, 3-bit price and 4-bit credit of the current machine.
- Provides:
  - a 2^SEL_W-entry writable price table;
  - a saturating credit accumulator;
  - a tick-driven inactivity timeout;
  - cancel;
  - change return as a unit-by-unit ready/valid stream.
- Sits between the keypad/coin decoders (upstream) and the display/ejector drivers (downstream). Clocked by the system clock; slow timing comes from a 1 Hz enable pulse.

Parameters:
- SEL_W, 4: product-select code width; price table depth = 2**SEL_W.
- CRED_W, 8: credit and price width, in smallest-coin units.
- TIMEOUT_TICKS, 15: tick pulses of inactivity in PAY before refund.
- DEFAULT_PRICE, 3: reset value of every price entry; 0 means product absent.

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- tick  in  1  1 Hz single-cycle enable
- key_valid  in  1  one-cycle pulse, product selected
- key_code  in  SEL_W  selected product index
- coin_valid  in  1  one-cycle pulse, coin inserted
- coin_value  in  CRED_W  value of inserted coin
- cancel  in  1  user cancel request (level, sampled per cycle)
- price_we  in  1  price table write enable
- price_addr  in  SEL_W  price table write address
- price_data  in  CRED_W  price table write data
- change_ready  in  1  ejector accepts one unit this cycle
- change_valid  out  1  one change unit pending
- dispense  out  1  one-cycle release pulse
- disp_prod  out  SEL_W  product being released, valid with dispense
- invalid_sel  out  1  one-cycle pulse, selected entry has price 0
- coin_reject  out  1  one-cycle pulse, coin arrived while not accepting
- credit  out  CRED_W  current credit
- estado  out  2  IDLE=00, PAY=01, DISPENSE=10, REFUND=11

Behaviour:
- Reset (asynchronous, reset_n low):
  - estado=IDLE, credit=0, all pulses and change_valid=0, disp_prod=0;
  - timer=0, latched selection and latched price=0;
  - every price entry=DEFAULT_PRICE.
  - Reset asserted mid-operation aborts immediately: no dispense, credit lost.
- Price table:
  - Write on a clk edge with price_we; visible from the next cycle.
  - Writes are allowed in any state.
  - A transaction compares against price_lat, captured at selection, so later writes to that entry do not affect it.
- Coins:
  - Accepted in IDLE and PAY: credit <= min(credit + coin_value, 2^CRED_W-1). Saturation discards the excess silently.
  - In DISPENSE/REFUND the coin is ignored and coin_reject pulses on the next cycle.
- IDLE:
  - key_valid with price[key_code]==0: invalid_sel pulses next cycle, stay IDLE.
  - key_valid with nonzero price: latch sel/price_lat, timer=0, go PAY.
  - cancel with credit>0: go REFUND.
- PAY, evaluated on registered credit (coin accepted in cycle N is compared in cycle N+1):
  - credit >= price_lat: go DISPENSE.
  - Otherwise cancel: go REFUND.
  - Otherwise timer reaches TIMEOUT_TICKS: go REFUND.
  - Priority, highest first: payment complete, cancel, timeout.
  - Timer increments on tick and clears on any accepted coin or key_valid.
  - key_valid in PAY reselects (same absent-product rule) and clears the timer.
- DISPENSE: single cycle.
  - dispense=1, disp_prod=sel;
  - credit <= credit - price_lat;
  - next state REFUND if remainder > 0, else IDLE.
- REFUND:
  - change_valid = (credit != 0).
  - Each cycle with change_valid && change_ready: credit decrements by 1.
  - change_valid holds, with credit stable, while change_ready is low.
  - Go IDLE in the cycle after credit reaches 0.
- Simultaneous events:
  - coin+cancel in PAY: coin is added, and the refund includes it;
  - coin+key in IDLE: both accepted;
  - key_valid is ignored in DISPENSE/REFUND.
- tick is ignored outside PAY.

Test Plan:
- Reset, key_code=5 (price 3), coins 1,1,1 → dispense pulse with disp_prod=5, credit 0, back to IDLE with no change_valid.
- Write price[2]=4, select 2, coin 5 → dispense; REFUND with change_valid, ready held high → exactly 1 unit handed over, then IDLE.
- Write price[7]=0, select 7 → invalid_sel pulse, estado stays 00; select 1 → PAY.
- Select 0, coin 2, 15 ticks with no activity → REFUND; ready toggled 1/0 → 2 units over 4 cycles, credit holds while ready=0.
- Coin 200 then 100 with CRED_W=8 → credit 255; cancel → 255 change units, then IDLE.
- Coin pulse during DISPENSE → coin_reject pulse, credit unchanged. reset_n low mid-REFUND → immediate IDLE, credit 0, change_valid 0.
